// File: rtl/echo_fifo_n.sv
module echo_fifo_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned REPW  = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             respond_rule__ENA,
  output logic             respond_rule__RDY,
  input  logic             say__ENA,
  input  logic [WIDTH-1:0] say_v,
  input  logic [REPW-1:0]  say_reps,
  output logic             say__RDY,
  output logic             ind_heard__ENA,
  output logic [WIDTH-1:0] ind_heard_heard_v,
  input  logic             ind_heard__RDY,
  output logic [CW-1:0]    occupancy
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [REPW-1:0]  reps_q [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [REPW-1:0]  rep_cnt;

  logic             say_fire;
  logic             resp_fire;
  logic             rep_last;
  logic             pop;
  logic [REPW-1:0]  eff_reps;

  always_comb begin
    say__RDY          = (count < FULL);
    respond_rule__RDY = (count != '0) & ind_heard__RDY;
    say_fire          = say__ENA & say__RDY;
    resp_fire         = respond_rule__ENA & respond_rule__RDY;
    ind_heard__ENA    = resp_fire;
    ind_heard_heard_v = data_q[rd_ptr];
    rep_last          = (rep_cnt == (reps_q[rd_ptr] - REPW'(1)));
    pop               = resp_fire & rep_last;
    eff_reps          = (say_reps == '0) ? REPW'(1) : say_reps;
    occupancy         = count;
  end

  always_ff @(posedge CLK) begin
    if (nRST && say_fire) begin
      data_q[wr_ptr] <= say_v;
      reps_q[wr_ptr] <= eff_reps;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rep_cnt <= '0;
    end else begin
      if (say_fire) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (resp_fire) begin
        if (rep_last) begin
          rd_ptr  <= rd_ptr + PW'(1);
          rep_cnt <= '0;
        end else begin
          rep_cnt <= rep_cnt + REPW'(1);
        end
      end
      if (say_fire && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !say_fire) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule
